// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_pkg
// Brief    : Shared types, state codes and opcode constants for the RV64I
//            multi-cycle controller.
// Revision : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

    typedef logic [31:0] inst_t;

    typedef logic [2:0] ctrl_state_enum;
    localparam ctrl_state_enum c_st_idle   = 3'd0;
    localparam ctrl_state_enum c_st_fetch  = 3'd1;
    localparam ctrl_state_enum c_st_decode = 3'd2;
    localparam ctrl_state_enum c_st_exec   = 3'd3;
    localparam ctrl_state_enum c_st_mem    = 3'd4;
    localparam ctrl_state_enum c_st_wb     = 3'd5;
    localparam ctrl_state_enum c_st_trap   = 3'd6;

    typedef enum logic [3:0] {
        ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC
    } op_class_enum;

    typedef enum logic [2:0] {
        IMM0, I_IMM, S_IMM, B_IMM, U_IMM, UJ_IMM
    } imm_op_enum;

    typedef enum logic [1:0] {
        WB_ALU, WB_MEM, WB_PC4, WB_IMM
    } wb_sel_enum;

    localparam logic [6:0] c_opc_load      = 7'b0000011;
    localparam logic [6:0] c_opc_op_imm    = 7'b0010011;
    localparam logic [6:0] c_opc_op_imm_32 = 7'b0011011;
    localparam logic [6:0] c_opc_jalr      = 7'b1100111;
    localparam logic [6:0] c_opc_store     = 7'b0100011;
    localparam logic [6:0] c_opc_branch    = 7'b1100011;
    localparam logic [6:0] c_opc_lui       = 7'b0110111;
    localparam logic [6:0] c_opc_auipc     = 7'b0010111;
    localparam logic [6:0] c_opc_jal       = 7'b1101111;
    localparam logic [6:0] c_opc_op        = 7'b0110011;
    localparam logic [6:0] c_opc_op_32     = 7'b0111011;

    localparam logic [1:0] c_cause_none    = 2'b00;
    localparam logic [1:0] c_cause_illegal = 2'b01;
    localparam logic [1:0] c_cause_imem_to = 2'b10;
    localparam logic [1:0] c_cause_dmem_to = 2'b11;

    function automatic wb_sel_enum wb_sel_of(input op_class_enum oc);
        case (oc)
            LOAD:      return WB_MEM;
            JAL, JALR: return WB_PC4;
            LUI:       return WB_IMM;
            default:   return WB_ALU;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_decode
// Brief    : Combinational opcode classifier: op class, immediate select,
//            ALU operand selects and illegal-opcode flag.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [3:0] op_class,
    output logic [2:0] immgen_op,
    output logic       alu_b_imm,
    output logic       alu_a_pc,
    output logic       illegal
);

    always_comb begin
        op_class  = ALU_R;
        immgen_op = IMM0;
        alu_b_imm = 1'b1;
        alu_a_pc  = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            c_opc_load: begin
                op_class  = LOAD;
                immgen_op = I_IMM;
            end
            c_opc_op_imm, c_opc_op_imm_32: begin
                op_class  = ALU_I;
                immgen_op = I_IMM;
            end
            c_opc_jalr: begin
                op_class  = JALR;
                immgen_op = I_IMM;
            end
            c_opc_store: begin
                op_class  = STORE;
                immgen_op = S_IMM;
            end
            // Branch target PC+imm comes from the ALU; the compare is separate.
            c_opc_branch: begin
                op_class  = BRANCH;
                immgen_op = B_IMM;
                alu_a_pc  = 1'b1;
            end
            c_opc_lui: begin
                op_class  = LUI;
                immgen_op = U_IMM;
            end
            c_opc_auipc: begin
                op_class  = AUIPC;
                immgen_op = U_IMM;
                alu_a_pc  = 1'b1;
            end
            c_opc_jal: begin
                op_class  = JAL;
                immgen_op = UJ_IMM;
                alu_a_pc  = 1'b1;
            end
            c_opc_op, c_opc_op_32: begin
                op_class  = ALU_R;
                alu_b_imm = 1'b0;
            end
            default: begin
                illegal   = 1'b1;
                alu_b_imm = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : RV64I multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
//            Optional perf counters under MULTICYCLE_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        br_taken,
    output logic [2:0]  immgen_op,
    output logic        alu_b_imm,
    output logic        alu_a_pc,
    output logic        pc_we,
    output logic        npc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
`ifdef MULTICYCLE_CTRL_PERF_EN
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt,
`endif
    output logic        trap,
    output logic [1:0]  trap_cause
);

    ctrl_state_enum r_state;
    ctrl_state_enum w_state_nx;
    op_class_enum   r_op_class;
    logic [6:0]     r_opcode;
    logic [2:0]     r_immgen_op;
    logic           r_alu_b_imm;
    logic           r_alu_a_pc;
    logic [1:0]     r_wb_sel;
    logic [1:0]     r_trap_cause;
    logic           w_expire;

    logic [3:0]     w_dec_class;
    logic [2:0]     w_dec_imm;
    logic           w_dec_b_imm;
    logic           w_dec_a_pc;
    logic           w_dec_illegal;
    logic           w_unused_rdata;

    // Only the opcode field is needed here; the datapath owns the full IR.
    assign w_unused_rdata = ^imem_rdata[31:7];

    multicycle_ctrl_decode u_decode (
        .opcode    (r_opcode),
        .op_class  (w_dec_class),
        .immgen_op (w_dec_imm),
        .alu_b_imm (w_dec_b_imm),
        .alu_a_pc  (w_dec_a_pc),
        .illegal   (w_dec_illegal)
    );

    logic w_exec, w_wb, w_is_branch, w_is_store, w_is_jump;
    assign w_exec      = (r_state == c_st_exec);
    assign w_wb        = (r_state == c_st_wb);
    assign w_is_branch = (r_op_class == BRANCH);
    assign w_is_store  = (r_op_class == STORE);
    assign w_is_jump   = (r_op_class == JAL) || (r_op_class == JALR);

    assign imem_req   = (r_state == c_st_fetch);
    assign ir_we      = imem_req & imem_ack;
    assign dmem_req   = (r_state == c_st_mem);
    assign dmem_we    = dmem_req & w_is_store;
    assign pc_we      = (w_exec & w_is_branch) | (dmem_req & w_is_store & dmem_ack) | w_wb;
    assign npc_sel    = (w_exec & w_is_branch & br_taken) | (w_wb & w_is_jump);
    assign rf_we      = w_wb;
    assign trap       = (r_state == c_st_trap);
    assign trap_cause = r_trap_cause;
    assign immgen_op  = r_immgen_op;
    assign alu_b_imm  = r_alu_b_imm;
    assign alu_a_pc   = r_alu_a_pc;
    assign wb_sel     = r_wb_sel;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_st_idle:   w_state_nx = c_st_fetch;
            c_st_fetch: begin
                if (imem_ack)      w_state_nx = c_st_decode;
                else if (w_expire) w_state_nx = c_st_trap;
            end
            c_st_decode: w_state_nx = w_dec_illegal ? c_st_trap : c_st_exec;
            c_st_exec: begin
                if (w_is_branch)                             w_state_nx = c_st_fetch;
                else if (w_is_store || r_op_class == LOAD)   w_state_nx = c_st_mem;
                else                                         w_state_nx = c_st_wb;
            end
            c_st_mem: begin
                if (dmem_ack)      w_state_nx = w_is_store ? c_st_fetch : c_st_wb;
                else if (w_expire) w_state_nx = c_st_trap;
            end
            c_st_wb:     w_state_nx = c_st_fetch;
            c_st_trap:   w_state_nx = c_st_trap;
            default:     w_state_nx = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_opcode     <= 7'd0;
            r_op_class   <= ALU_R;
            r_immgen_op  <= IMM0;
            r_alu_b_imm  <= 1'b0;
            r_alu_a_pc   <= 1'b0;
            r_wb_sel     <= WB_ALU;
            r_trap_cause <= c_cause_none;
        end else begin
            r_state <= w_state_nx;
            if (ir_we) begin
                r_opcode <= imem_rdata[6:0];
            end
            if (r_state == c_st_decode) begin
                if (w_dec_illegal) begin
                    r_op_class   <= ALU_R;
                    r_immgen_op  <= IMM0;
                    r_alu_b_imm  <= 1'b0;
                    r_alu_a_pc   <= 1'b0;
                    r_wb_sel     <= WB_ALU;
                    r_trap_cause <= c_cause_illegal;
                end else begin
                    r_op_class  <= op_class_enum'(w_dec_class);
                    r_immgen_op <= w_dec_imm;
                    r_alu_b_imm <= w_dec_b_imm;
                    r_alu_a_pc  <= w_dec_a_pc;
                    r_wb_sel    <= wb_sel_of(op_class_enum'(w_dec_class));
                end
            end
            if (r_state == c_st_fetch && w_state_nx == c_st_trap) begin
                r_trap_cause <= c_cause_imem_to;
            end
            if (r_state == c_st_mem && w_state_nx == c_st_trap) begin
                r_trap_cause <= c_cause_dmem_to;
            end
        end
    end

    generate
        if (ACK_TIMEOUT > 0) begin : g_timeout
            localparam int c_wait_w = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
            logic [c_wait_w-1:0] r_wait;
            logic                w_waiting;

            assign w_waiting = (imem_req & ~imem_ack) | (dmem_req & ~dmem_ack);
            // An ack in the expiry cycle still wins because w_waiting drops.
            assign w_expire  = w_waiting && (r_wait == c_wait_w'(ACK_TIMEOUT - 1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wait <= '0;
                end else if (w_state_nx != r_state) begin
                    r_wait <= '0;
                end else if (w_waiting) begin
                    r_wait <= r_wait + 1'b1;
                end
            end
        end else begin : g_no_timeout
            assign w_expire = 1'b0;
        end
    endgenerate

`ifdef MULTICYCLE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= 64'd0;
            instret_cnt <= 64'd0;
        end else begin
            if (r_state != c_st_idle && r_state != c_st_trap) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            if (pc_we) begin
                instret_cnt <= instret_cnt + 64'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Self-checking bench: instruction vector table with a per-cycle
//            expected-strobe scoreboard, plus reset/trap/timeout sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam int c_k_alu = 0;
    localparam int c_k_br  = 1;
    localparam int c_k_ld  = 2;
    localparam int c_k_st  = 3;
    localparam int c_k_jmp = 4;

    // strobe bits: {imem_req, ir_we, dmem_req, dmem_we, pc_we, npc_sel, rf_we, trap}
    localparam logic [7:0] c_ireq = 8'h80;
    localparam logic [7:0] c_irwe = 8'h40;
    localparam logic [7:0] c_dreq = 8'h20;
    localparam logic [7:0] c_dwe  = 8'h10;
    localparam logic [7:0] c_pcwe = 8'h08;
    localparam logic [7:0] c_npc  = 8'h04;
    localparam logic [7:0] c_rfwe = 8'h02;
    localparam logic [7:0] c_trap = 8'h01;

    typedef struct {
        logic [31:0] inst;
        int          kind;
        int          idly;
        int          ddly;
        logic        br;
        logic        noise;
        logic [6:0]  dec;   // {immgen_op, wb_sel, alu_b_imm, alu_a_pc}
    } vec_t;

    typedef struct {
        logic [7:0] strb;
        logic [1:0] cause;
        logic       chk;
        logic [6:0] dec;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0, br_taken = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req, ir_we, dmem_req, dmem_we, alu_b_imm, alu_a_pc;
    logic        pc_we, npc_sel, rf_we, trap;
    logic [2:0]  immgen_op;
    logic [1:0]  wb_sel, trap_cause;

    logic        rst2 = 1'b1;
    logic        imem_ack2 = 1'b0, dmem_ack2 = 1'b0;
    logic [31:0] imem_rdata2 = 32'd0;
    logic        imem_req2, ir_we2, dmem_req2, dmem_we2, alu_b_imm2, alu_a_pc2;
    logic        pc_we2, npc_sel2, rf_we2, trap2;
    logic [2:0]  immgen_op2;
    logic [1:0]  wb_sel2, trap_cause2;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [63:0] cyc1, ins1, cyc2, ins2;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(.ACK_TIMEOUT(0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .br_taken(br_taken), .immgen_op(immgen_op),
        .alu_b_imm(alu_b_imm), .alu_a_pc(alu_a_pc), .pc_we(pc_we),
        .npc_sel(npc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
`ifdef MULTICYCLE_CTRL_PERF_EN
        .cycle_cnt(cyc1), .instret_cnt(ins1),
`endif
        .trap(trap), .trap_cause(trap_cause)
    );

    multicycle_ctrl #(.ACK_TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst2),
        .imem_req(imem_req2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
        .ir_we(ir_we2), .dmem_req(dmem_req2), .dmem_we(dmem_we2),
        .dmem_ack(dmem_ack2), .br_taken(1'b0), .immgen_op(immgen_op2),
        .alu_b_imm(alu_b_imm2), .alu_a_pc(alu_a_pc2), .pc_we(pc_we2),
        .npc_sel(npc_sel2), .rf_we(rf_we2), .wb_sel(wb_sel2),
`ifdef MULTICYCLE_CTRL_PERF_EN
        .cycle_cnt(cyc2), .instret_cnt(ins2),
`endif
        .trap(trap2), .trap_cause(trap_cause2)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q[$];
    exp_t e_chk;
    vec_t vecs[12];

    wire [7:0] w_strb = {imem_req, ir_we, dmem_req, dmem_we, pc_we, npc_sel, rf_we, trap};
    wire [6:0] w_dec  = {immgen_op, wb_sel, alu_b_imm, alu_a_pc};

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e_chk = q.pop_front();
            cmp("strobes", 16'(w_strb), 16'(e_chk.strb));
            cmp("trap_cause", 16'(trap_cause), 16'(e_chk.cause));
            if (e_chk.chk) cmp("decoded", 16'(w_dec), 16'(e_chk.dec));
        end
    end

    task automatic step(input logic r, input logic ia, input logic da, input logic br,
                        input logic [7:0] strb, input logic [1:0] cause,
                        input logic chk, input logic [6:0] dec);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; imem_ack = ia; dmem_ack = da; br_taken = br;
        e.strb = strb; e.cause = cause; e.chk = chk; e.dec = dec;
        q.push_back(e);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 7'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 7'h00);
    endtask

    task automatic run_vec(input vec_t v);
        logic       n;
        logic [7:0] s;
        n = v.noise;
        imem_rdata = v.inst;
        for (int k = 0; k <= v.idly; k++)
            step(1'b0, k == v.idly, n, v.br, c_ireq | ((k == v.idly) ? c_irwe : 8'h00),
                 2'b00, 1'b0, 7'h00);
        step(1'b0, n, n, v.br, 8'h00, 2'b00, 1'b0, 7'h00);
        s = (v.kind == c_k_br) ? (c_pcwe | (v.br ? c_npc : 8'h00)) : 8'h00;
        step(1'b0, n, n, v.br, s, 2'b00, 1'b1, v.dec);
        if (v.kind == c_k_ld || v.kind == c_k_st) begin
            for (int k = 0; k <= v.ddly; k++) begin
                s = c_dreq;
                if (v.kind == c_k_st) s = s | c_dwe | ((k == v.ddly) ? c_pcwe : 8'h00);
                step(1'b0, n, k == v.ddly, v.br, s, 2'b00, 1'b1, v.dec);
            end
        end
        if (v.kind != c_k_br && v.kind != c_k_st) begin
            s = c_rfwe | c_pcwe | ((v.kind == c_k_jmp) ? c_npc : 8'h00);
            step(1'b0, n, n, v.br, s, 2'b00, 1'b1, v.dec);
        end
    endtask

    task automatic rst2_pulse();
        @(posedge clk); #1; rst2 = 1'b1; imem_ack2 = 1'b0; dmem_ack2 = 1'b0;
        @(posedge clk); #1; rst2 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        //            inst          kind     idly ddly br    noise  {imm,wb,bimm,apc}
        vecs[0]  = '{32'h00500093, c_k_alu, 0, 0, 1'b0, 1'b0, {3'd1, 2'd0, 1'b1, 1'b0}};
        vecs[1]  = '{32'h00112423, c_k_st,  0, 3, 1'b0, 1'b0, {3'd2, 2'd0, 1'b1, 1'b0}};
        vecs[2]  = '{32'h00000463, c_k_br,  0, 0, 1'b1, 1'b0, {3'd3, 2'd0, 1'b1, 1'b1}};
        vecs[3]  = '{32'h123450b7, c_k_alu, 0, 0, 1'b0, 1'b0, {3'd4, 2'd3, 1'b1, 1'b0}};
        vecs[4]  = '{32'h010000ef, c_k_jmp, 0, 0, 1'b0, 1'b0, {3'd5, 2'd2, 1'b1, 1'b1}};
        vecs[5]  = '{32'h00012083, c_k_ld,  6, 1, 1'b0, 1'b0, {3'd1, 2'd1, 1'b1, 1'b0}};
        vecs[6]  = '{32'h002081b3, c_k_alu, 0, 0, 1'b0, 1'b1, {3'd0, 2'd0, 1'b0, 1'b0}};
        vecs[7]  = '{32'h00000463, c_k_br,  1, 0, 1'b0, 1'b0, {3'd3, 2'd0, 1'b1, 1'b1}};
        vecs[8]  = '{32'h00008067, c_k_jmp, 0, 0, 1'b1, 1'b1, {3'd1, 2'd2, 1'b1, 1'b0}};
        vecs[9]  = '{32'h00001297, c_k_alu, 2, 0, 1'b0, 1'b0, {3'd4, 2'd0, 1'b1, 1'b1}};
        vecs[10] = '{32'h0050009b, c_k_alu, 0, 0, 1'b0, 1'b0, {3'd1, 2'd0, 1'b1, 1'b0}};
        vecs[11] = '{32'h002081bb, c_k_alu, 0, 0, 1'b0, 1'b0, {3'd0, 2'd0, 1'b0, 1'b0}};

        do_reset();
        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Illegal opcode: absorbing trap, strobes stay low even with stray acks.
        imem_rdata = 32'hFFFFFFFF;
        step(1'b0, 1'b1, 1'b0, 1'b0, c_ireq | c_irwe, 2'b00, 1'b0, 7'h00);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 2'b00, 1'b0, 7'h00);
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b1, 1'b1, 1'b1, c_trap, 2'b01, 1'b0, 7'h00);
        do_reset();

        // Reset asserted while a load waits in MEM.
        imem_rdata = 32'h00012083;
        step(1'b0, 1'b1, 1'b0, 1'b0, c_ireq | c_irwe, 2'b00, 1'b0, 7'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, {3'd1, 2'd1, 1'b1, 1'b0});
        step(1'b0, 1'b0, 1'b0, 1'b0, c_dreq, 2'b00, 1'b1, {3'd1, 2'd1, 1'b1, 1'b0});
        step(1'b0, 1'b0, 1'b0, 1'b0, c_dreq, 2'b00, 1'b1, {3'd1, 2'd1, 1'b1, 1'b0});
        do_reset();
        run_vec(vecs[0]);

        @(posedge clk); @(posedge clk);
        cmp("scoreboard_drained", 16'(q.size()), 16'd0);

        // Timeout instance: imem never acks -> trap after 4 request cycles.
        imem_rdata2 = 32'h00500093;
        rst2_pulse();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            cmp("to_imem_req", 16'(imem_req2), 16'd1);
            cmp("to_no_trap_yet", 16'(trap2), 16'd0);
        end
        @(posedge clk); @(negedge clk);
        cmp("to_imem_trap", 16'({trap2, trap_cause2, imem_req2}), 16'({1'b1, 2'b10, 1'b0}));

        // Ack on the expiry cycle wins over the timeout.
        rst2_pulse();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; imem_ack2 = (i == 3);
            @(negedge clk);
            cmp("to_edge_irwe", 16'(ir_we2), 16'(i == 3));
        end
        @(posedge clk); #1; imem_ack2 = 1'b0;
        @(negedge clk);
        cmp("to_edge_decode", 16'({trap2, imem_req2}), 16'd0);

        // Data-side timeout on a load.
        imem_rdata2 = 32'h00012083;
        rst2_pulse();
        @(posedge clk); #1; imem_ack2 = 1'b1;
        @(posedge clk); #1; imem_ack2 = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            cmp("to_dmem_req", 16'({dmem_req2, trap2}), 16'({1'b1, 1'b0}));
        end
        @(posedge clk); @(negedge clk);
        cmp("to_dmem_trap", 16'({trap2, trap_cause2, dmem_req2}), 16'({1'b1, 2'b11, 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
